// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: per-register {flush, stall} words, PC hold/redirect.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_MemRead,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_branch_taken,
  input  logic                 if_busy,
  input  logic                 mem_busy,
  output logic                 pc_stall,
  output logic                 pc_redirect,
  output logic [1:0]           ifid_fs,
  output logic [1:0]           idex_fs,
  output logic [1:0]           exmem_fs,
  output logic [1:0]           memwb_fs,
  output logic                 discard_active,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  // state   | meaning
  // RUN     | normal hazard resolution
  // DISCARD | wrong-path fetch still in flight; its returning word is dropped
  typedef enum logic {ST_RUN = 1'b0, ST_DISCARD = 1'b1} state_t;

  localparam logic [1:0] FS_ADV   = 2'b00;
  localparam logic [1:0] FS_HOLD  = 2'b01;
  localparam logic [1:0] FS_FLUSH = 2'b10;

  state_t state_q, state_d;
  logic   load_use;

  always_comb begin
    load_use = ex_MemRead && (ex_rd_addr != 5'd0) &&
               ((id_use_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                (id_use_rs2 && (ex_rd_addr == id_rs2_addr)));
    pc_stall       = 1'b0;
    pc_redirect    = 1'b0;
    ifid_fs        = FS_ADV;
    idex_fs        = FS_ADV;
    exmem_fs       = FS_ADV;
    memwb_fs       = FS_ADV;
    discard_active = 1'b0;
    state_d        = state_q;
    if (!reset) begin
      pc_stall = 1'b1;
      ifid_fs  = FS_FLUSH;
      idex_fs  = FS_FLUSH;
      exmem_fs = FS_FLUSH;
      memwb_fs = FS_FLUSH;
      state_d  = ST_RUN;
    end else if (state_q == ST_DISCARD) begin
      // ID/EX carries bubbles here, so neither a branch nor a load-use can be live
      discard_active = 1'b1;
      pc_stall       = 1'b1;
      ifid_fs        = FS_FLUSH;
      if (mem_busy) begin
        idex_fs  = FS_HOLD;
        exmem_fs = FS_HOLD;
        memwb_fs = FS_FLUSH;
      end
      if (!if_busy) state_d = ST_RUN;
    end else if (mem_busy) begin
      pc_stall = 1'b1;
      ifid_fs  = FS_HOLD;
      idex_fs  = FS_HOLD;
      exmem_fs = FS_HOLD;
      memwb_fs = FS_FLUSH;
    end else if (ex_branch_taken) begin
      pc_redirect = 1'b1;
      ifid_fs     = FS_FLUSH;
      idex_fs     = FS_FLUSH;
      if (if_busy) state_d = ST_DISCARD;
    end else if (load_use || if_busy) begin
      pc_stall = 1'b1;
      ifid_fs  = FS_HOLD;
      idex_fs  = FS_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_events_q, flush_events_d;

  // Saturating counters; they only clear on reset
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall && !(&stall_cycles_q))    stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    if (pc_redirect && !(&flush_events_q)) flush_events_d = flush_events_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RISC-V pipeline. Generates the 2-bit {flush, stall} control word for each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold/redirect strobes. It resolves load-use hazards, taken-branch redirects, and instruction/data bus wait states. It also tracks a wrong-path fetch that is still in flight after a redirect, so that the stale word is discarded.

Parameters:
CNT_WIDTH, 32, width of performance counters (only used with HAZARD_PERF_EN)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-low reset
id_rs1_addr  in  5  rs1 index of instruction in ID
id_rs2_addr  in  5  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_MemRead  in  1  MemRead_out of ID/EX register
ex_rd_addr  in  5  rd_addr_out of ID/EX register
ex_branch_taken  in  1  EX resolved a taken branch/jump
if_busy  in  1  instruction fetch bus access pending (no ack yet)
mem_busy  in  1  data bus access in MEM pending (no ack yet)
pc_stall  out  1  hold PC
pc_redirect  out  1  PC loads branch target this cycle
ifid_fs  out  2  {flush, stall} for IF/ID
idex_fs  out  2  {flush, stall} for ID/EX
exmem_fs  out  2  {flush, stall} for EX/MEM
memwb_fs  out  2  {flush, stall} for MEM/WB
discard_active  out  1  state == DISCARD
stall_cycles  out  CNT_WIDTH  perf: cycles with pc_stall=1
flush_events  out  CNT_WIDTH  perf: redirects taken

Behaviour:
- Encoding per register: 2'b00 = advance, 2'b01 = hold, 2'b10 = bubble/flush. The block never drives 2'b11.
- Outputs are combinational from inputs and state, giving a same-cycle response. State and counters update on posedge clk.
- While reset==0: state=RUN; counters=0; all *_fs=2'b10; pc_stall=1; pc_redirect=0; discard_active=0.
- States: RUN and DISCARD.
- load_use = ex_MemRead & (ex_rd_addr!=0) & ((id_use_rs1 & ex_rd_addr==id_rs1_addr) | (id_use_rs2 & ex_rd_addr==id_rs2_addr)).
- Priority in RUN, highest first:
  1. mem_busy: pc_stall=1; IF/ID, ID/EX, EX/MEM=01; MEM/WB=10. ex_branch_taken is ignored (the branch is held in EX and is re-evaluated once mem_busy drops).
  2. ex_branch_taken: pc_redirect=1, pc_stall=0; IF/ID=10, ID/EX=10; EX/MEM, MEM/WB=00. If if_busy=1 in the same cycle, next state=DISCARD.
  3. load_use: pc_stall=1; IF/ID=01; ID/EX=10; others 00. Lasts exactly one cycle because the load advances to MEM.
  4. if_busy: pc_stall=1; IF/ID=01; ID/EX=10; others 00.
  5. Otherwise: all 00, pc_stall=0.
- DISCARD state (a wrong-path fetch is still in flight):
  - IF/ID=10 every cycle and pc_stall=1.
  - Other stages follow the RUN rules: mem_busy rule 1 applies to ID/EX through MEM/WB. ID/EX is 00 unless the mem_busy rule applies.
  - A new ex_branch_taken is impossible here because ID/EX holds bubbles.
  - On the cycle if_busy==0: the returning word is flushed (IF/ID=10), pc_stall=1, and next state=RUN.
  - The fetch of the redirect target starts in the following cycle.
- Reset mid-DISCARD returns to RUN; the bus side is reset independently.
- Simultaneous mem_busy & load_use: the mem_busy rule wins; load_use is re-evaluated afterwards because ID/EX was held.

Optional Feature:
HAZARD_PERF_EN:
- Defined: stall_cycles increments on every non-reset cycle with pc_stall=1. flush_events increments on every pc_redirect=1. Both counters saturate at all-ones and clear only on reset.
- Undefined: no counter flops are built; stall_cycles and flush_events are tied to 0.

Test Plan:
- Load-use: ex_MemRead=1, ex_rd_addr=5, id_rs2_addr=5, id_use_rs2=1 -> one cycle with pc_stall=1, ifid_fs=01, idex_fs=10, exmem_fs=00. Next cycle (ex_MemRead=0) all 00.
- Load to x0: same stimulus but ex_rd_addr=0 -> no stall, all 00.
- Branch with idle fetch: ex_branch_taken=1, if_busy=0 -> pc_redirect=1, ifid_fs=10, idex_fs=10; state stays RUN.
- Branch with fetch in flight: ex_branch_taken=1, if_busy=1 for 3 more cycles -> DISCARD for 3 cycles plus the if_busy-low cycle. ifid_fs=10 and pc_stall=1 throughout; discard_active=1; RUN afterwards. flush_events +1 (HAZARD_PERF_EN).
- mem_busy=1 for 4 cycles with ex_branch_taken=1 -> pc_redirect=0, memwb_fs=10, others 01 for 4 cycles. On the 5th cycle pc_redirect=1. stall_cycles +4.
- Reset: reset=0 for 1 cycle while in DISCARD -> all fs=10, pc_stall=1. After release, state=RUN, counters=0.
